// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared types and constants for the SRAM arbiter.
//   arb_state_t : sequencer states
//   PORT_CPU/LD : requester indices (also the bit positions in grant vectors)
//   cnt_width   : width of a down-counting-free wait counter covering 0..max-1
package sram_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WR_SETUP,
    ST_WR_PULSE,
    ST_WR_HOLD,
    ST_ACK
  } arb_state_t;

  localparam int PORT_CPU = 0;
  localparam int PORT_LD  = 1;

  // Counter only needs to reach max(a,b)-1; keep at least one bit.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin arbiter.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   req_i[1:0]    : requests (bit index = port index)
//   en_i          : grant enable; the priority pointer moves only when high
//   gnt_o[1:0]    : one-hot grant (combinational), zero when no request
module rr_arbiter2
  import sram_arb_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] gnt_o
);

  // prio_q names the port that wins a tie; after a grant it points at the
  // other port, so the port not granted last wins the next tie.
  logic prio_q, prio_d;

  always_comb begin
    gnt_o  = req_i;
    prio_d = prio_q;
    if (req_i == 2'b11) begin
      gnt_o = prio_q ? 2'b10 : 2'b01;
    end
    if (en_i && (req_i != 2'b00)) begin
      prio_d = gnt_o[0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      prio_q <= 1'(PORT_CPU);
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: sequences an asynchronous SRAM and shares it between the
// processor port (cpu_*) and the loader/debug port (ld_*).
//   clk, reset            : clock, synchronous active-low reset
//   cpu_*/ld_* req,we,adr,wdata : request side
//   cpu_*/ld_* rdata,ack  : read data (held until that port's next read ack),
//                           one-cycle completion pulse
//   sram_ce_n/oe_n/we_n   : active-low SRAM strobes
//   sram_adr, sram_dout, sram_doe, sram_din : SRAM address/data bus
//   dbg_state_o           : current sequencer state
// Handshake: a requester raises req with we/adr/wdata stable and keeps them
// stable until ack pulses for one cycle; req still high after ack starts a
// new transaction, subject to round-robin fairness.
// Every output is registered and decoded from the next state, so strobes
// change exactly on the edge that enters each state.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int RD_WAIT    = 2,
  parameter int WR_PULSE   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_adr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_ack,
  input  logic                  ld_req,
  input  logic                  ld_we,
  input  logic [ADDR_WIDTH-1:0] ld_adr,
  input  logic [DATA_WIDTH-1:0] ld_wdata,
  output logic [DATA_WIDTH-1:0] ld_rdata,
  output logic                  ld_ack,
  output logic                  sram_ce_n,
  output logic                  sram_oe_n,
  output logic                  sram_we_n,
  output logic [ADDR_WIDTH-1:0] sram_adr,
  output logic [DATA_WIDTH-1:0] sram_dout,
  output logic                  sram_doe,
  input  logic [DATA_WIDTH-1:0] sram_din,
  output arb_state_t            dbg_state_o
);

  localparam int CW = cnt_width(RD_WAIT, WR_PULSE);
  localparam logic [CW-1:0] RD_LAST = CW'(RD_WAIT - 1);
  localparam logic [CW-1:0] WR_LAST = CW'(WR_PULSE - 1);

  arb_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic port_q, port_d;  // granted port index
  logic [1:0] gnt;
  logic gnt_en;

  // sram_adr_q/sram_dout_q double as the latched request fields.
  logic ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d, doe_q, doe_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d, ld_rdata_q, ld_rdata_d;
  logic [1:0] ack_q, ack_d;

  rr_arbiter2 u_rr (
    .clk_i  (clk),
    .rst_ni (reset),
    .req_i  ({ld_req, cpu_req}),
    .en_i   (gnt_en),
    .gnt_o  (gnt)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    port_d      = port_q;
    gnt_en      = 1'b0;
    adr_d       = adr_q;
    dout_d      = dout_q;
    cpu_rdata_d = cpu_rdata_q;
    ld_rdata_d  = ld_rdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cpu_req || ld_req) begin
          gnt_en = 1'b1;
          port_d = gnt[PORT_LD];
          cnt_d  = '0;
          if (gnt[PORT_CPU]) begin
            adr_d   = cpu_adr;
            dout_d  = cpu_wdata;
            state_d = cpu_we ? ST_WR_SETUP : ST_RD;
          end else begin
            adr_d   = ld_adr;
            dout_d  = ld_wdata;
            state_d = ld_we ? ST_WR_SETUP : ST_RD;
          end
        end
      end
      ST_RD: begin
        if (cnt_q == RD_LAST) begin
          state_d = ST_ACK;
          // Capture on the edge leaving the last RD cycle.
          if (port_q) ld_rdata_d  = sram_din;
          else        cpu_rdata_d = sram_din;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WR_SETUP: begin
        state_d = ST_WR_PULSE;
        cnt_d   = '0;
      end
      ST_WR_PULSE: begin
        if (cnt_q == WR_LAST) state_d = ST_WR_HOLD;
        else                  cnt_d   = cnt_q + 1'b1;
      end
      ST_WR_HOLD: state_d = ST_ACK;
      ST_ACK:     state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    // Output decode from the next state.
    ce_n_d = 1'b1;
    oe_n_d = 1'b1;
    we_n_d = 1'b1;
    doe_d  = 1'b0;
    ack_d  = 2'b00;
    unique case (state_d)
      ST_RD: begin
        ce_n_d = 1'b0;
        oe_n_d = 1'b0;
      end
      ST_WR_SETUP, ST_WR_HOLD: begin
        ce_n_d = 1'b0;
        doe_d  = 1'b1;
      end
      ST_WR_PULSE: begin
        ce_n_d = 1'b0;
        we_n_d = 1'b0;
        doe_d  = 1'b1;
      end
      ST_ACK:  ack_d = port_d ? 2'b10 : 2'b01;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      port_q      <= 1'b0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      doe_q       <= 1'b0;
      adr_q       <= '0;
      dout_q      <= '0;
      cpu_rdata_q <= '0;
      ld_rdata_q  <= '0;
      ack_q       <= 2'b00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      port_q      <= port_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      doe_q       <= doe_d;
      adr_q       <= adr_d;
      dout_q      <= dout_d;
      cpu_rdata_q <= cpu_rdata_d;
      ld_rdata_q  <= ld_rdata_d;
      ack_q       <= ack_d;
    end
  end

  assign sram_ce_n   = ce_n_q;
  assign sram_oe_n   = oe_n_q;
  assign sram_we_n   = we_n_q;
  assign sram_doe    = doe_q;
  assign sram_adr    = adr_q;
  assign sram_dout   = dout_q;
  assign cpu_rdata   = cpu_rdata_q;
  assign ld_rdata    = ld_rdata_q;
  assign cpu_ack     = ack_q[PORT_CPU];
  assign ld_ack      = ack_q[PORT_LD];
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sram_arbiter.sv
module tb_sram_arbiter;
  import sram_arb_pkg::*;

  localparam int RW = 2;
  localparam int WP = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic       cpu_req = 0, cpu_we = 0, ld_req = 0, ld_we = 0;
  logic [7:0] cpu_adr = 0, cpu_wdata = 0, ld_adr = 0, ld_wdata = 0;
  logic [7:0] cpu_rdata, ld_rdata, sram_adr, sram_dout, sram_din;
  logic       cpu_ack, ld_ack, sram_ce_n, sram_oe_n, sram_we_n, sram_doe;
  arb_state_t dbg_state;

  sram_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .RD_WAIT(RW), .WR_PULSE(WP)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .ld_req(ld_req), .ld_we(ld_we), .ld_adr(ld_adr), .ld_wdata(ld_wdata),
    .ld_rdata(ld_rdata), .ld_ack(ld_ack),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .sram_adr(sram_adr), .sram_dout(sram_dout), .sram_doe(sram_doe),
    .sram_din(sram_din), .dbg_state_o(dbg_state)
  );

  // ---------------- board SRAM model ----------------
  logic [7:0] mem [256];
  initial foreach (mem[i]) mem[i] = 8'h00;
  always @(negedge clk)
    if (!sram_ce_n && !sram_we_n && sram_doe) mem[sram_adr] <= sram_dout;
  assign sram_din = (!sram_ce_n && !sram_oe_n) ? mem[sram_adr] : 8'hEE;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [9:0] exp_q[$];       // {port, is_read, expected rdata} in ack order
  logic [7:0] ref_mem [256];  // intended memory contents
  logic [7:0] cpu_rd_m = 0, ld_rd_m = 0;
  logic mon_en = 0;
  initial foreach (ref_mem[i]) ref_mem[i] = 8'h00;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void push_exp(input int port, input logic we,
                                   input logic [7:0] adr, input logic [7:0] wd);
    logic [7:0] d;
    if (we) ref_mem[adr] = wd;
    d = we ? 8'h00 : ref_mem[adr];
    exp_q.push_back({port[0], ~we, d});
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      chk("oe_we_both_low", int'(!sram_oe_n && !sram_we_n), 0);
      chk("acks_onehot", int'(cpu_ack && ld_ack), 0);
      chk("doe_with_oe", int'(sram_doe && !sram_oe_n), 0);
      if (cpu_ack || ld_ack) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_ack", 1, 0);
        end else begin
          logic [9:0] e;
          e = exp_q.pop_front();
          chk("ack_port", int'(ld_ack), int'(e[9]));
          if (e[8]) chk("ack_rdata", e[9] ? ld_rdata : cpu_rdata, e[7:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input int port, input logic r, input logic we,
                       input logic [7:0] adr, input logic [7:0] wd);
    if (port == 0) begin
      cpu_req = r; cpu_we = we; cpu_adr = adr; cpu_wdata = wd;
    end else begin
      ld_req = r; ld_we = we; ld_adr = adr; ld_wdata = wd;
    end
  endtask

  // One isolated transaction; returns ack cycle and per-cycle strobe masks.
  task automatic run_single(input int port, input logic we, input logic [7:0] adr,
                            input logic [7:0] wd, output int ack_cyc,
                            output logic [15:0] we_m, output logic [15:0] doe_m,
                            output logic [15:0] oe_m, output logic [15:0] ce_m);
    int cyc;
    ack_cyc = -1; we_m = 0; doe_m = 0; oe_m = 0; ce_m = 0;
    @(negedge clk);
    push_exp(port, we, adr, wd);
    drive(port, 1'b1, we, adr, wd);
    for (cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (cyc < 16) begin
        we_m[cyc] = ~sram_we_n; doe_m[cyc] = sram_doe;
        oe_m[cyc] = ~sram_oe_n; ce_m[cyc] = ~sram_ce_n;
      end
      if ((port == 0 && cpu_ack) || (port == 1 && ld_ack)) begin
        ack_cyc = cyc;
        drive(port, 1'b0, we, adr, wd);
        break;
      end
    end
    if (ack_cyc < 0) begin
      chk("single_timeout", 1, 0);
      drive(port, 1'b0, we, adr, wd);
    end
  endtask

  // Both ports request together; the CPU is expected to be served first.
  task automatic run_both(input logic cwe, input logic [7:0] cadr, input logic [7:0] cwd,
                          input logic lwe, input logic [7:0] ladr, input logic [7:0] lwd);
    int first = -1;
    bit cdone = 0, ldone = 0;
    @(negedge clk);
    push_exp(0, cwe, cadr, cwd);
    push_exp(1, lwe, ladr, lwd);
    drive(0, 1'b1, cwe, cadr, cwd);
    drive(1, 1'b1, lwe, ladr, lwd);
    for (int c = 0; c < 60 && !(cdone && ldone); c++) begin
      @(negedge clk);
      if (cpu_ack) begin
        cdone = 1; cpu_req = 0;
        if (first < 0) first = 0;
      end
      if (ld_ack) begin
        ldone = 1; ld_req = 0;
        if (first < 0) first = 1;
      end
    end
    chk("both_done", int'(cdone && ldone), 1);
    chk("both_first_port", first, 0);
    cpu_req = 0; ld_req = 0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int         port;
    logic       we;
    logic [7:0] adr;
    logic [7:0] wd;
    int         exp_ack;
    logic [15:0] exp_we, exp_doe, exp_oe, exp_ce;
  } vec_t;

  function automatic logic [15:0] span(input int lo, input int hi);
    logic [15:0] m = 0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic vec_t mk(input int port, input logic we,
                              input logic [7:0] adr, input logic [7:0] wd);
    vec_t v;
    v.port = port; v.we = we; v.adr = adr; v.wd = wd;
    if (we) begin
      v.exp_ack = WP + 3; v.exp_ce = span(1, WP + 2); v.exp_doe = span(1, WP + 2);
      v.exp_we = span(2, WP + 1); v.exp_oe = 0;
    end else begin
      v.exp_ack = RW + 1; v.exp_ce = span(1, RW); v.exp_oe = span(1, RW);
      v.exp_we = 0; v.exp_doe = 0;
    end
    return v;
  endfunction

  vec_t vecs[8];

  // ---------------- main sequence ----------------
  initial begin
    int ack_c;
    logic [15:0] wm, dm, om, cm;
    int ld_acks, ld_before_cpu;
    bit cpu_done;
    bit saw_we_low;

    vecs[0] = mk(0, 1'b1, 8'h10, 8'hA5);
    vecs[1] = mk(0, 1'b0, 8'h10, 8'h00);
    vecs[2] = mk(1, 1'b0, 8'h10, 8'h00);
    vecs[3] = mk(1, 1'b1, 8'h11, 8'h5A);
    vecs[4] = mk(0, 1'b0, 8'h11, 8'h00);
    vecs[5] = mk(1, 1'b0, 8'h00, 8'h00);
    vecs[6] = mk(0, 1'b1, 8'hFF, 8'hC3);
    vecs[7] = mk(1, 1'b0, 8'hFF, 8'h00);

    // Reset with both requests high: nothing may move.
    reset = 0;
    drive(0, 1'b1, 1'b1, 8'h55, 8'h77);
    drive(1, 1'b1, 1'b0, 8'h66, 8'h88);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      mon_en = 1;
      chk("rst_strobes", {sram_ce_n, sram_oe_n, sram_we_n}, 3'b111);
      chk("rst_doe", sram_doe, 0);
      chk("rst_acks", {cpu_ack, ld_ack}, 0);
      chk("rst_rdata", {cpu_rdata, ld_rdata}, 0);
      chk("rst_adr", sram_adr, 0);
      chk("rst_state", dbg_state, ST_IDLE);
    end
    reset = 1;
    cpu_req = 0; ld_req = 0;

    // Table-driven single transactions.
    foreach (vecs[i]) begin
      run_single(vecs[i].port, vecs[i].we, vecs[i].adr, vecs[i].wd, ack_c, wm, dm, om, cm);
      chk($sformatf("v%0d_ack_cycle", i), ack_c, vecs[i].exp_ack);
      chk($sformatf("v%0d_we_mask", i), wm, vecs[i].exp_we);
      chk($sformatf("v%0d_doe_mask", i), dm, vecs[i].exp_doe);
      chk($sformatf("v%0d_oe_mask", i), om, vecs[i].exp_oe);
      chk($sformatf("v%0d_ce_mask", i), cm, vecs[i].exp_ce);
      if (!vecs[i].we) begin
        if (vecs[i].port == 0) cpu_rd_m = ref_mem[vecs[i].adr];
        else                   ld_rd_m  = ref_mem[vecs[i].adr];
      end
      chk($sformatf("v%0d_cpu_rdata", i), cpu_rdata, cpu_rd_m);
      chk($sformatf("v%0d_ld_rdata", i), ld_rdata, ld_rd_m);
    end

    // Simultaneous requests, twice: CPU then loader both times.
    run_both(1'b0, 8'h01, 8'h00, 1'b1, 8'h02, 8'h3C);
    cpu_rd_m = ref_mem[8'h01];
    run_both(1'b0, 8'h01, 8'h00, 1'b1, 8'h02, 8'h3C);
    chk("both_ld_rdata_kept", ld_rdata, ld_rd_m);
    run_single(0, 1'b0, 8'h02, 8'h00, ack_c, wm, dm, om, cm);
    chk("rd_02", cpu_rdata, 8'h3C);
    cpu_rd_m = 8'h3C;

    // Loader streams 4 reads; a single CPU read must get in after the first.
    @(negedge clk);
    push_exp(1, 1'b0, 8'h10, 8'h00);
    push_exp(0, 1'b0, 8'h11, 8'h00);
    push_exp(1, 1'b0, 8'h10, 8'h00);
    push_exp(1, 1'b0, 8'h10, 8'h00);
    push_exp(1, 1'b0, 8'h10, 8'h00);
    drive(1, 1'b1, 1'b0, 8'h10, 8'h00);
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 8'h11, 8'h00);
    ld_acks = 0; ld_before_cpu = -1; cpu_done = 0;
    for (int c = 0; c < 100 && !(cpu_done && ld_acks == 4); c++) begin
      @(negedge clk);
      if (cpu_ack) begin
        cpu_done = 1; cpu_req = 0; ld_before_cpu = ld_acks;
      end
      if (ld_ack) begin
        ld_acks++;
        if (ld_acks == 4) ld_req = 0;
      end
    end
    cpu_req = 0; ld_req = 0;
    chk("stream_ld_acks", ld_acks, 4);
    chk("no_starve", ld_before_cpu, 1);
    cpu_rd_m = ref_mem[8'h11];
    ld_rd_m  = ref_mem[8'h10];

    // Reset during the first WR_PULSE cycle of a write 0xFF @ 0x20.
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 8'h20, 8'hFF);
    saw_we_low = 0;
    @(negedge clk);                         // cycle 1: WR_SETUP
    chk("rstw_setup_we", sram_we_n, 1);
    @(negedge clk);                         // cycle 2: WR_PULSE
    saw_we_low = !sram_we_n;
    chk("rstw_pulse_we", sram_we_n, 0);
    reset = 0;
    cpu_req = 0;
    @(negedge clk);                         // cycle 3: reset values
    chk("rstw_strobes", {sram_ce_n, sram_oe_n, sram_we_n}, 3'b111);
    chk("rstw_doe", sram_doe, 0);
    chk("rstw_rdata", {cpu_rdata, ld_rdata}, 0);
    chk("rstw_state", dbg_state, ST_IDLE);
    reset = 1;
    cpu_rd_m = 0; ld_rd_m = 0;
    for (int c = 0; c < 6; c++) @(negedge clk);  // unexpected ack would be flagged
    // The we_n pulse had started, so the board SRAM has taken the new byte.
    if (saw_we_low) ref_mem[8'h20] = 8'hFF;
    run_single(0, 1'b0, 8'h20, 8'h00, ack_c, wm, dm, om, cm);
    chk("rstw_readback", cpu_rdata, 8'hFF);
    chk("rstw_ld_rdata", ld_rdata, 0);

    repeat (3) @(negedge clk);
    chk("sb_leftover", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Sequences the external asynchronous SRAM (active-low ce/oe/we, 8-bit address, 8-bit data) and shares it between two requesters: the processor memory port and a loader/debug port that fills or inspects memory. It converts a simple req/ack handshake into correctly ordered SRAM strobes, with programmable read wait and write pulse lengths. It sits between `top`'s memory interface and the board-level SRAM, replacing the fixed PCB strobe logic.

## Interface

Parameters:
- ADDR_WIDTH, 8, SRAM address width
- DATA_WIDTH, 8, SRAM data width
- RD_WAIT, 2, cycles oe_n is held low before read data is captured (≥1)
- WR_PULSE, 1, cycles we_n is held low (≥1)

Ports:
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-low reset
- cpu_req, ld_req  in  1  request; held high with fields stable until the matching ack
- cpu_we, ld_we  in  1  1 = write, 0 = read
- cpu_adr, ld_adr  in  ADDR_WIDTH  access address
- cpu_wdata, ld_wdata  in  DATA_WIDTH  write data
- cpu_rdata, ld_rdata  out  DATA_WIDTH  read data; valid from the ack cycle until that port's next read ack
- cpu_ack, ld_ack  out  1  one-cycle completion pulse
- sram_ce_n, sram_oe_n, sram_we_n  out  1  SRAM strobes, active low
- sram_adr  out  ADDR_WIDTH  SRAM address
- sram_dout  out  DATA_WIDTH  data driven to SRAM
- sram_doe  out  1  tristate enable for sram_dout (board drives bus when 1)
- sram_din  in  DATA_WIDTH  data read from SRAM bus

## Operation

- All outputs are registered. Reset values: strobes = 1, sram_adr = 0, sram_dout = 0, sram_doe = 0, acks = 0, both rdata = 0, FSM = IDLE, round-robin pointer = CPU.
- States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, ACK.
- IDLE: if any req, grant per round-robin and latch the winner's adr/we/wdata. Next state is RD if read, otherwise WR_SETUP. No req: stay in IDLE.
- Round robin:
  - A lone requester always wins.
  - If both request, the port not granted last wins.
  - The pointer updates on every grant.
- RD (RD_WAIT cycles): ce_n = 0, oe_n = 0, sram_adr = latched address. sram_din is captured into the granted port's rdata at the edge leaving the last RD cycle.
- WR_SETUP (1 cycle): ce_n = 0, sram_adr and sram_dout valid, sram_doe = 1, we_n = 1.
- WR_PULSE (WR_PULSE cycles): as WR_SETUP, but we_n = 0.
- WR_HOLD (1 cycle): we_n = 1; address, data and doe are still held.
- ACK (1 cycle): strobes all 1, doe = 0, granted port's ack = 1. Next state is always IDLE.
- Invariants:
  - oe_n and we_n are never both 0.
  - sram_doe = 1 only in write states.
  - oe_n = 0 only in RD.
  - At most one ack is high.
- Writes never modify rdata. Reads update only the granted port's rdata.
- A requester that keeps req high after its ack starts a new transaction. Fairness still applies.
- reset low mid-transaction:
  - Next edge forces the reset values; the transaction is dropped and no ack is issued.
  - rdata is cleared to 0.

## Timing

- Cycle 0 is the IDLE cycle in which req is sampled high.
- Read: RD in cycles 1..RD_WAIT; ack high in cycle RD_WAIT+1 (default: cycle 3).
- Write: WR_SETUP in cycle 1, WR_PULSE in cycles 2..WR_PULSE+1, WR_HOLD in cycle WR_PULSE+2, ack in cycle WR_PULSE+3 (default: cycle 4).
- One IDLE cycle always separates transactions.
  - Back-to-back read throughput is one access per RD_WAIT+2 cycles.
  - Back-to-back write throughput is one access per WR_PULSE+4 cycles.
- Address and data are stable for one full cycle before and after the we_n low pulse.
- Requests arriving in non-IDLE states wait; they are never lost while req is held.

## Structure

- Package `sram_arb_pkg`: state enum `arb_state_t`, port index constants `PORT_CPU = 0`, `PORT_LD = 1`.
- Sub-module `rr_arbiter2`:
  - Inputs: 2 requests and a grant-enable.
  - Outputs: one-hot grant.
  - Owns the pointer register, which updates only when grant-enable is high.
- Top holds the FSM, wait counter sized for max(RD_WAIT, WR_PULSE), latched request fields and output registers.

## Test plan

- Reset: hold reset = 0 for 2 cycles with both reqs high → strobes = 1, doe = 0, acks = 0, rdata = 0, and no strobe activity until reset = 1.
- CPU write 0xA5 @ 0x10, then CPU read @ 0x10:
  - Write: ack in cycle 4, we_n low in exactly cycle 2, doe in cycles 1–3.
  - Read: ack in cycle 3, cpu_rdata = 0xA5, ld_rdata unchanged.
- Simultaneous CPU read @ 0x01 and loader write 0x3C @ 0x02, both held:
  - CPU is served first, then the loader.
  - Re-issuing both gives CPU, loader again.
  - A subsequent read @ 0x02 returns 0x3C.
- Loader holds req continuously for 4 reads while CPU requests once → CPU is granted after the loader's first transaction, not starved.
- Reset asserted in WR_PULSE of a write 0xFF @ 0x20 (memory previously 0x00) → no ack, strobes high next cycle, and a later read @ 0x20 returns 0x00 only if we_n pulse had not started (check model for RD_WAIT = 2, WR_PULSE = 3).
- Throughout all tests, assert oe_n & we_n never both 0 and acks one-hot-or-zero.
